// File: rtl/ifmap_row_feeder.sv
// ifmap_row_feeder: tags upstream pixels with row markers and writes them into the IF buffer.
// Optional stall counter enabled by defining FEEDER_STALL_CNT_EN.
module ifmap_row_feeder #(
   parameter int IF_SCRATCH_WIDTH = 16,
   parameter int ROW_LEN_W        = 6,
   parameter int ROWS_W           = 6
`ifdef FEEDER_STALL_CNT_EN
   , parameter int STALL_W        = 16
`endif
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ROW_LEN_W-1:0]          row_len,
   input  logic [ROWS_W-1:0]             num_rows,
   input  logic                          pix_valid,
   input  logic [IF_SCRATCH_WIDTH-1:0]   pix_data,
   output logic                          pix_ready,
   input  logic                          IF_full,
   output logic                          IF_wen,
   output logic [IF_SCRATCH_WIDTH+1:0]   IF_din,
   output logic                          busy,
   output logic                          done
`ifdef FEEDER_STALL_CNT_EN
   , output logic [STALL_W-1:0]          stall_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;
   state_t                state_q;
   logic [ROW_LEN_W-1:0]  col_q, row_len_q;
   logic [ROWS_W-1:0]     row_q, num_rows_q;
   logic                  busy_q, done_q;
   logic                  feeding, fire, last_col, last_row;
   logic [1:0]            tag;
   // handshake, tag and write data are combinational so each accepted pixel is written the same cycle
   always_comb begin
      feeding   = state_q == FEED;
      pix_ready = feeding & ~IF_full;
      fire      = pix_ready & pix_valid;
      last_col  = col_q == row_len_q - ROW_LEN_W'(1);
      last_row  = row_q == num_rows_q - ROWS_W'(1);
      tag       = {col_q == '0, last_col};
      IF_wen    = fire;
      IF_din    = fire ? {tag, pix_data} : '0;
      busy      = busy_q;
      done      = done_q;
   end
   // job FSM with position counters; busy/done are registered alongside the state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         col_q      <= '0;
         row_q      <= '0;
         row_len_q  <= '0;
         num_rows_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               row_len_q  <= row_len;
               num_rows_q <= num_rows;
               col_q      <= '0;
               row_q      <= '0;
               busy_q     <= 1'b1;
               if (row_len == '0 || num_rows == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= FEED;
               end
            end
            FEED: if (fire) begin
               if (last_col) begin
                  col_q <= '0;
                  row_q <= row_q + ROWS_W'(1);
                  if (last_row) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  col_q <= col_q + ROW_LEN_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end
`ifdef FEEDER_STALL_CNT_EN
   logic [STALL_W-1:0] stall_q;
   assign stall_cnt = stall_q;
   // saturating count of cycles a valid pixel was held back by a full buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_q <= '0;
      else if (state_q == IDLE && start) stall_q <= '0;
      else if (feeding && pix_valid && IF_full && ~&stall_q) stall_q <= stall_q + STALL_W'(1);
   end
`endif
endmodule

// File: tb/tb_ifmap_row_feeder.sv
// tb_ifmap_row_feeder: randomized scoreboard bench for ifmap_row_feeder.
module tb_ifmap_row_feeder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  row_len = '0;
   logic [5:0]  num_rows = '0;
   logic        pix_valid = 1'b0;
   logic [15:0] pix_data = '0;
   logic        pix_ready;
   logic        IF_full = 1'b0;
   logic        IF_wen;
   logic [17:0] IF_din;
   logic        busy, done;
`ifdef FEEDER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif
   int vectors = 0;
   int miscompares = 0;
   logic [17:0] exp_q[$];
   logic [15:0] pix_q[$];

   ifmap_row_feeder dut (
      .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .IF_full(IF_full), .IF_wen(IF_wen), .IF_din(IF_din), .busy(busy), .done(done)
`ifdef FEEDER_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every buffer write must match the next expected tagged word
   always @(negedge clk) begin
      if (IF_wen === 1'b1) begin
         if (exp_q.size() == 0) check("wen_unexpected", IF_wen, 0);
         else check("if_din", IF_din, exp_q.pop_front());
      end
   end

   // reference: build the whole job's pixel list and expected word stream from the row rules
   task automatic plan(input int len, input int rows, input int fixed);
      pix_q.delete();
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < len; c++) begin
            logic [15:0] p;
            logic [1:0]  t;
            p = (fixed >= 0) ? 16'(fixed + c) : 16'($urandom);
            t = {c == 0, c == len - 1};
            pix_q.push_back(p);
            exp_q.push_back({t, p});
         end
   endtask

   task automatic pulse_start(input int len, input int rows);
      @(posedge clk); #1;
      start = 1'b1; row_len = 6'(len); num_rows = 6'(rows);
      @(posedge clk); #1;
      start = 1'b0; row_len = 6'($urandom); num_rows = 6'($urandom);
   endtask

   // mode 0 always valid/never full, 1 random, 2 full 3 cycles after 2nd word, 3 start re-pulsed, 4 reset after 2 words
   task automatic run_job(input int len, input int rows, input int mode);
      int idx = 0, cycles = 0, stalls = 0, hold = 3;
      int n;
      bit fired;
      n = pix_q.size();
      pulse_start(len, rows);
      while (idx < n && cycles < 2000) begin
         pix_data  = pix_q[idx];
         pix_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         IF_full   = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (mode == 2 && idx == 2 && hold > 0) begin IF_full = 1'b1; hold--; end
         start = (mode == 3 && cycles == 1);
         row_len = 6'd1; num_rows = 6'd1;
         if (mode == 4 && idx == 2) begin
            #2 rst = 1'b0;
            #1;
            check("rst_wen", IF_wen, 0);
            check("rst_ready", pix_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            exp_q.delete();
            pix_valid = 1'b0;
            @(posedge clk); #1 rst = 1'b1;
            return;
         end
         if (pix_valid && IF_full) stalls++;
         fired = pix_valid && !IF_full;
         @(negedge clk);
         check("pix_ready", pix_ready, !IF_full);
         check("if_wen", IF_wen, fired);
         check("busy_feed", busy, 1);
         @(posedge clk); #1;
         start = 1'b0;
         cycles++;
         if (fired) idx++;
      end
      if (idx < n) check("job_timeout", idx, n);
      pix_valid = 1'b0; IF_full = 1'b0;
      if (mode == 0 || mode == 3) check("feed_cycles", cycles, n);
      @(negedge clk);
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_wen", IF_wen, 0);
      check("words_left", exp_q.size(), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_clear", done, 0);
      check("busy_clear", busy, 0);
`ifdef FEEDER_STALL_CNT_EN
      check("stall_cnt", stall_cnt, stalls);
`endif
   endtask

   task automatic zero_job(input int len, input int rows);
      pix_valid = 1'b1; pix_data = 16'h1234;
      pulse_start(len, rows);
      @(negedge clk);
      check("zero_done", done, 1);
      check("zero_busy", busy, 1);
      check("zero_wen", IF_wen, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("zero_idle_busy", busy, 0);
      check("zero_idle_wen", IF_wen, 0);
      pix_valid = 1'b0;
   endtask

   initial begin
      pix_valid = 1'b1;
      #3;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_wen", IF_wen, 0);
      check("reset_ready", pix_ready, 0);
      pix_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      // directed pixels 1,0,3,16 for one 4-pixel row
      pix_q = '{16'd1, 16'd0, 16'd3, 16'd16};
      exp_q = '{18'h20001, 18'h00000, 18'h00003, 18'h10010};
      run_job(4, 1, 0);
      plan(4, 1, 1);
      run_job(4, 1, 2);
      pix_q = '{16'hFFFB, 16'h0007};
      exp_q = '{18'h3FFFB, 18'h30007};
      run_job(1, 2, 0);
      zero_job(0, 3);
      zero_job(5, 0);
      plan(4, 2, -1);
      run_job(4, 2, 4);
      plan(3, 2, -1);
      run_job(3, 2, 0);
      plan(5, 2, -1);
      run_job(5, 2, 3);
      for (int j = 0; j < 20; j++) begin
         int l, r;
         l = $urandom_range(1, 7);
         r = $urandom_range(1, 4);
         plan(l, r, -1);
         run_job(l, r, 1);
      end
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
